// File: rtl/mem_access_stage.sv
// MEM stage: data-memory request/ack handshake, load alignment and
// registered control bundle toward write-back.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [63:0] ALURsltp,
  input  logic [31:0] PCp,
  input  logic [4:0]  RDstp,
  input  logic [1:0]  WDSelp,
  input  logic        RFWrp,
  input  logic        MDIVp,
  input  logic        MemRp,
  input  logic        MemWp,
  input  logic [1:0]  MemSz,
  input  logic        MemSgn,
  input  logic [31:0] WrDat,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic [63:0] ALURslt,
  output logic [31:0] MemRslt,
  output logic [31:0] PC,
  output logic [4:0]  RDst,
  output logic [1:0]  WDSel,
  output logic        RFWr,
  output logic        MDIV,
  output logic        valid_out,
  output logic        err_align,
  output logic        err_tmo
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [63:0] q_alu;
  logic [31:0] q_pc;
  logic [4:0]  q_rdst;
  logic [1:0]  q_wdsel;
  logic        q_rfwr;
  logic        q_mdiv;
  logic        q_memr;
  logic        q_memw;
  logic [1:0]  q_sz;
  logic        q_sgn;
  logic [31:0] q_wdat;
  logic        q_flush;

  logic        busy;
  logic [63:0] c_alu;
  logic [31:0] c_pc;
  logic [4:0]  c_rdst;
  logic [1:0]  c_wdsel;
  logic        c_rfwr;
  logic        c_mdiv;
  logic        c_memr;
  logic        c_memw;
  logic [1:0]  c_sz;
  logic        c_sgn;
  logic [31:0] c_wdat;
  logic [31:0] addr;

  logic        memop;
  logic        mis;
  logic        go;
  logic        tmo;
  logic        done;
  logic        align;
  logic [31:0] lane;
  logic [31:0] ld_data;

  // While waiting, the request is driven from the captured instruction
  assign busy    = (state == WAIT);
  assign c_alu   = busy ? q_alu   : ALURsltp;
  assign c_pc    = busy ? q_pc    : PCp;
  assign c_rdst  = busy ? q_rdst  : RDstp;
  assign c_wdsel = busy ? q_wdsel : WDSelp;
  assign c_rfwr  = busy ? q_rfwr  : RFWrp;
  assign c_mdiv  = busy ? q_mdiv  : MDIVp;
  assign c_memr  = busy ? q_memr  : MemRp;
  assign c_memw  = busy ? q_memw  : MemWp;
  assign c_sz    = busy ? q_sz    : MemSz;
  assign c_sgn   = busy ? q_sgn   : MemSgn;
  assign c_wdat  = busy ? q_wdat  : WrDat;
  assign addr    = c_alu[31:0];

  assign memop = valid_in & (MemRp | MemWp);
  assign mis   = ((c_sz == 2'b01) & addr[0]) |
                 (c_sz[1] & (|addr[1:0]));
  assign go    = ~busy & memop & ~mis & ~flush;
  assign align = ~busy & memop & mis & ~flush;

  assign dm_req    = ~rst & (busy | go);
  assign dm_we     = c_memw;
  assign dm_addr   = {addr[31:2], 2'b00};
  assign tmo       = dm_req & ~dm_ack & (cnt == LAST);
  assign mem_stall = dm_req & ~dm_ack & ~tmo;

  assign done = busy ? (dm_ack & ~(q_flush | flush))
                     : ((valid_in & ~memop & ~flush) | (go & dm_ack));

  always_comb begin
    dm_be    = 4'b1111;
    dm_wdata = c_wdat;
    unique case (c_sz)
      2'b00: begin
        dm_be    = 4'b0001 << addr[1:0];
        dm_wdata = {4{c_wdat[7:0]}};
      end
      2'b01: begin
        dm_be    = addr[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{c_wdat[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dm_rdata >> {addr[1:0], 3'b000};

  always_comb begin
    ld_data = dm_rdata;
    unique case (c_sz)
      2'b00:   ld_data = {{24{c_sgn & lane[7]}}, lane[7:0]};
      2'b01:   ld_data = {{16{c_sgn & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      q_alu   <= '0;
      q_pc    <= '0;
      q_rdst  <= '0;
      q_wdsel <= '0;
      q_rfwr  <= 1'b0;
      q_mdiv  <= 1'b0;
      q_memr  <= 1'b0;
      q_memw  <= 1'b0;
      q_sz    <= '0;
      q_sgn   <= 1'b0;
      q_wdat  <= '0;
      q_flush <= 1'b0;
    end else if (!busy) begin
      q_alu   <= ALURsltp;
      q_pc    <= PCp;
      q_rdst  <= RDstp;
      q_wdsel <= WDSelp;
      q_rfwr  <= RFWrp;
      q_mdiv  <= MDIVp;
      q_memr  <= MemRp;
      q_memw  <= MemWp;
      q_sz    <= MemSz;
      q_sgn   <= MemSgn;
      q_wdat  <= WrDat;
      q_flush <= 1'b0;
      if (go & ~dm_ack & ~tmo) begin
        state <= WAIT;
        cnt   <= CW'(1);
      end
    end else if (dm_ack | tmo) begin
      state   <= IDLE;
      cnt     <= '0;
      q_flush <= 1'b0;
    end else begin
      cnt     <= cnt + CW'(1);
      q_flush <= q_flush | flush;
    end
  end

  // Every edge that does not complete an instruction is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALURslt   <= '0;
      MemRslt   <= '0;
      PC        <= '0;
      RDst      <= '0;
      WDSel     <= '0;
      RFWr      <= 1'b0;
      MDIV      <= 1'b0;
      valid_out <= 1'b0;
      err_align <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      err_align <= align;
      err_tmo   <= tmo;
      valid_out <= done;
      if (done) begin
        ALURslt <= c_alu;
        MemRslt <= c_memr ? ld_data : 32'h0;
        PC      <= c_pc;
        RDst    <= c_rdst;
        WDSel   <= c_wdsel;
        RFWr    <= c_rfwr;
        MDIV    <= c_mdiv;
      end else begin
        ALURslt <= '0;
        MemRslt <= '0;
        PC      <= '0;
        RDst    <= '0;
        WDSel   <= '0;
        RFWr    <= 1'b0;
        MDIV    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random and directed instructions
// against a behavioural model, with a separate WB-side monitor.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, flush;
  logic [63:0] ALURsltp;
  logic [31:0] PCp;
  logic [4:0]  RDstp;
  logic [1:0]  WDSelp;
  logic        RFWrp, MDIVp, MemRp, MemWp;
  logic [1:0]  MemSz;
  logic        MemSgn;
  logic [31:0] WrDat;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_ack, mem_stall;
  logic [63:0] ALURslt;
  logic [31:0] MemRslt, PC;
  logic [4:0]  RDst;
  logic [1:0]  WDSel;
  logic        RFWr, MDIV, valid_out, err_align, err_tmo;

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
    .ALURsltp(ALURsltp), .PCp(PCp), .RDstp(RDstp), .WDSelp(WDSelp),
    .RFWrp(RFWrp), .MDIVp(MDIVp), .MemRp(MemRp), .MemWp(MemWp),
    .MemSz(MemSz), .MemSgn(MemSgn), .WrDat(WrDat),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .ALURslt(ALURslt), .MemRslt(MemRslt),
    .PC(PC), .RDst(RDst), .WDSel(WDSel), .RFWr(RFWr), .MDIV(MDIV),
    .valid_out(valid_out), .err_align(err_align), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic [63:0] alu;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [1:0]  ws;
    logic        rf, md, mr, mw;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] wd;
  } ins_t;

  typedef struct {
    logic        vo, ea, et;
    logic [63:0] alu;
    logic [31:0] mr, pc;
    logic [4:0]  rd;
    logic [1:0]  ws;
    logic        rf, md;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, want);
  endtask

  function automatic bit m_mis(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return a != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return {4{w[7:0]}};
    if (sz == 2'd1) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sg,
                                       input logic [1:0] a, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * a);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  function automatic exp_t m_done(input ins_t s, input logic [31:0] res);
    exp_t e;
    e = '{default: '0};
    e.vo = 1'b1; e.alu = s.alu; e.mr = res; e.pc = s.pc;
    e.rd = s.rd; e.ws = s.ws; e.rf = s.rf; e.md = s.md;
    return e;
  endfunction

  task automatic drive(input ins_t s);
    valid_in = s.vi; ALURsltp = s.alu; PCp = s.pc; RDstp = s.rd;
    WDSelp = s.ws; RFWrp = s.rf; MDIVp = s.md; MemRp = s.mr;
    MemWp = s.mw; MemSz = s.sz; MemSgn = s.sg; WrDat = s.wd;
  endtask

  task automatic idle_in();
    valid_in = 0; flush = 0; dm_ack = 0; MemRp = 0; MemWp = 0;
  endtask

  function automatic ins_t rnd_ins();
    ins_t s;
    s.vi = 1'b1;
    s.alu = {$urandom, $urandom};
    s.pc = $urandom; s.rd = 5'($urandom); s.ws = 2'($urandom);
    s.rf = 1'($urandom); s.md = 1'($urandom);
    s.mr = 0; s.mw = 0;
    s.sz = 2'($urandom); s.sg = 1'($urandom); s.wd = $urandom;
    return s;
  endfunction

  function automatic ins_t mk(input logic mr, input logic mw, input logic [1:0] sz,
                              input logic sg, input logic [31:0] a,
                              input logic [31:0] wd);
    ins_t s;
    s = rnd_ins();
    s.mr = mr; s.mw = mw; s.sz = sz; s.sg = sg; s.wd = wd;
    s.alu = {32'h0, a};
    s.rf = mr;
    return s;
  endfunction

  // d: request cycle carrying dm_ack (>=TMO means never); fc: flush cycle
  task automatic issue(input ins_t s, input int d, input int fc,
                       input logic [31:0] rdv, input bit rdfix);
    logic [1:0] a;
    bit memop, mis, flushed, last;
    exp_t e;
    a = s.alu[1:0];
    memop = s.vi && (s.mr || s.mw);
    mis = m_mis(s.sz, a);
    flushed = 0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk);
      drive(s);
      flush = (c == fc);
      dm_ack = (c == d);
      dm_rdata = rdfix ? rdv : $urandom;
      #1;
      if (c == 0 && !(memop && !mis && fc != 0)) begin
        chk("no_req", dm_req, 0);
        chk("no_stall", mem_stall, 0);
        if (memop && mis && fc != 0) begin
          e = '{default: '0};
          e.ea = 1'b1;
          sbq.push_back(e);
        end else if (s.vi && !memop && fc != 0) begin
          sbq.push_back(m_done(s, 32'h0));
        end
        return;
      end
      chk("req", dm_req, 1);
      chk("we", dm_we, s.mw);
      chk("addr", dm_addr, {s.alu[31:2], 2'b00});
      chk("be", dm_be, m_be(s.sz, a));
      if (s.mw) chk("wdata", dm_wdata, m_wd(s.sz, s.wd));
      if (c >= 1 && c == fc) flushed = 1;
      last = (c == d) || (c == TMO - 1);
      chk("stall", mem_stall, !last);
      if (last) begin
        if (c == d) begin
          if (!flushed)
            sbq.push_back(m_done(s, s.mr ? m_ld(s.sz, s.sg, a, dm_rdata) : 32'h0));
        end else begin
          e = '{default: '0};
          e.et = 1'b1;
          sbq.push_back(e);
        end
        return;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (valid_out || err_align || err_tmo) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", {valid_out, err_align, err_tmo}, 0);
        end else begin
          e = sbq.pop_front();
          chk("valid_out", valid_out, e.vo);
          chk("err_align", err_align, e.ea);
          chk("err_tmo", err_tmo, e.et);
          chk("ALURslt", ALURslt, e.alu);
          chk("MemRslt", MemRslt, e.mr);
          chk("PC", PC, e.pc);
          chk("RDst", RDst, e.rd);
          chk("WDSel", WDSel, e.ws);
          chk("RFWr", RFWr, e.rf);
          chk("MDIV", MDIV, e.md);
        end
      end else begin
        chk("bubble_ctl", {RFWr, MDIV, MemRslt}, 0);
      end
    end
  end

  initial begin : stim
    ins_t s;
    int k, d, fc;
    rst = 1; idle_in();
    ALURsltp = '0; PCp = '0; RDstp = '0; WDSelp = '0; RFWrp = 0;
    MDIVp = 0; MemSz = '0; MemSgn = 0; WrDat = '0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", dm_req, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_alu", ALURslt, 0);
    chk("rst_pc", PC, 0);
    chk("rst_err", {err_align, err_tmo, RFWr, MDIV}, 0);
    rst = 0;

    issue(mk(1, 0, 2'd2, 0, 32'h100, 0), 0, -1, 32'hCAFE_BABE, 1);
    issue(mk(1, 0, 2'd0, 1, 32'h103, 0), 0, -1, 32'h80FF_0000, 1);
    issue(mk(1, 0, 2'd1, 0, 32'h102, 0), 1, -1, 32'h80FF_0000, 1);
    issue(mk(0, 1, 2'd0, 0, 32'h201, 32'h1234_5678), 3, -1, 0, 0);
    issue(mk(1, 0, 2'd2, 0, 32'h102, 0), 0, -1, 0, 0);
    issue(mk(1, 0, 2'd2, 0, 32'h104, 0), 99, -1, 0, 0);
    issue(mk(1, 0, 2'd2, 0, 32'h108, 0), 2, 1, 0, 0);
    issue(mk(1, 0, 2'd3, 1, 32'h10C, 0), 0, -1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      s = rnd_ins();
      k = $urandom_range(0, 9);
      if (k == 0) begin
        s.vi = 0; s.mr = 1'($urandom);
      end else if (k >= 3 && k <= 6) begin
        s.mr = 1;
      end else if (k >= 7) begin
        s.mw = 1;
      end
      if ($urandom_range(0, 1) == 1) s.alu[1:0] = 2'b00;
      d = $urandom_range(0, 5);
      fc = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
      issue(s, d, fc, 0, 0);
    end

    s = rnd_ins();
    issue(s, 0, -1, 0, 0);
    @(negedge clk);
    drive(mk(1, 0, 2'd2, 0, 32'h300, 0));
    flush = 0; dm_ack = 0;
    #1;
    chk("pre_rst_req", dm_req, 1);
    #1 rst = 1;
    #1;
    chk("arst_req", dm_req, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_alu", ALURslt, 0);
    chk("arst_pc", PC, 0);
    chk("arst_stall", mem_stall, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("wait_req", dm_req, 1);
    #1 rst = 1;
    #1;
    chk("wait_rst_req", dm_req, 0);
    chk("wait_rst_stall", mem_stall, 0);
    @(negedge clk);
    rst = 0;
    idle_in();
    issue(mk(1, 0, 2'd2, 0, 32'h100, 0), 0, -1, 32'h1357_9BDF, 1);

    @(negedge clk);
    idle_in();
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
